dmi_jtag_ctrl: RTL and testbench

DMI transaction controller behind the debug JTAG TAP. It owns the DTMCS and DMI data registers, shifting them with the TAP's capture, shift and update strobes. It turns each DMI update into one request/response handshake toward the debug module (DM) side, which normally passes through a CDC. It tracks the sticky busy/failed status defined by RISC-V debug spec 0.13 and runs entirely in the TCK domain.

---
 rtl/dmi_jtag_ctrl_pkg.sv | 48 ++++
 rtl/dmi_jtag_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dmi_jtag_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_jtag_ctrl_pkg.sv
// Shared debug package for the DMI JTAG controller: DTM op/error codes,
// FSM states, request/response/DTMCS layouts and the DTMCS version value.
package dmi_jtag_ctrl_pkg;

    // Debug spec 0.13 DTM version reported in dtmcs.version
    localparam logic [3:0] DtmVersion = 4'd1;

    typedef enum logic [1:0] {
        DtmNop   = 2'd0,
        DtmRead  = 2'd1,
        DtmWrite = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DmiOk     = 2'd0,
        DmiFailed = 2'd2,
        DmiBusy   = 2'd3
    } dmi_error_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } dmi_state_e;

    // Address is carried separately because its width is a block parameter
    typedef struct packed {
        logic [31:0] data;
        dtm_op_e     op;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } dmi_resp_t;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

endpackage

// File: rtl/dmi_jtag_ctrl.sv
// DMI transaction controller in the TCK domain. Owns the DTMCS and DMI data
// registers, turns each DMI update into one request/response handshake and
// keeps the sticky busy/failed status.
// Optional feature macro: DMI_JTAG_HARDRESET_EN enables dtmcs.dmihardreset
// (forces Idle, clears the error and pulses dmi_rst_no low for one cycle).
module dmi_jtag_ctrl
    import dmi_jtag_ctrl_pkg::*;
#(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned IdleHint  = 1
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 capture_i,
    input  logic                 shift_i,
    input  logic                 update_i,
    input  logic                 tdi_i,
    input  logic                 dtmcs_select_i,
    output logic                 dtmcs_tdo_o,
    input  logic                 dmi_select_i,
    output logic                 dmi_tdo_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [31:0]          dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic                 dmi_resp_err_i,
    output logic                 dmi_rst_no
);

    localparam int unsigned DmiWidth = AddrWidth + 34;

    dmi_state_e            state_reg, state_next;
    dmi_error_e            error_reg, error_next;
    logic [AddrWidth-1:0]  addr_reg, addr_next;
    dmi_req_t              req_reg, req_next;
    logic [31:0]           dtmcs_sr_reg, dtmcs_sr_next;
    logic [DmiWidth-1:0]   dmi_sr_reg, dmi_sr_next;

    dmi_resp_t             resp;
    dtmcs_t                dtmcs_cap;
    logic                  busy;
    logic [1:0]            cap_op;
    logic [1:0]            upd_op;
    logic [31:0]           upd_data;
    logic [AddrWidth-1:0]  upd_addr;

`ifdef DMI_JTAG_HARDRESET_EN
    logic                  hardreset_req;
    logic                  dmi_rst_n_reg;
`endif

    assign resp     = '{data: dmi_resp_data_i, err: dmi_resp_err_i};
    assign upd_op   = dmi_sr_reg[1:0];
    assign upd_data = dmi_sr_reg[33:2];
    assign upd_addr = dmi_sr_reg[DmiWidth-1:34];

    assign dtmcs_tdo_o    = dtmcs_sr_reg[0];
    assign dmi_tdo_o      = dmi_sr_reg[0];
    assign dmi_req_addr_o = addr_reg;
    assign dmi_req_op_o   = req_reg.op;
    assign dmi_req_data_o = req_reg.data;

    // Next-state logic: DMI DR, transaction FSM, then DTMCS (resets win last)
    always_comb begin
        state_next       = state_reg;
        error_next       = error_reg;
        addr_next        = addr_reg;
        req_next         = req_reg;
        dtmcs_sr_next    = dtmcs_sr_reg;
        dmi_sr_next      = dmi_sr_reg;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
`ifdef DMI_JTAG_HARDRESET_EN
        hardreset_req    = 1'b0;
`endif

        busy   = (state_reg != StIdle);
        cap_op = busy ? 2'b11 : error_reg;

        dtmcs_cap         = '0;
        dtmcs_cap.idle    = 3'(IdleHint);
        dtmcs_cap.dmistat = error_reg;
        dtmcs_cap.abits   = 6'(AddrWidth);
        dtmcs_cap.version = DtmVersion;

        // DMI data register: a capture or update while busy flags Busy
        if (dmi_select_i) begin
            if (capture_i) begin
                if (busy && (error_reg == DmiOk)) error_next = DmiBusy;
                dmi_sr_next = {addr_reg, req_reg.data, cap_op};
            end else if (shift_i) begin
                dmi_sr_next = {tdi_i, dmi_sr_reg[DmiWidth-1:1]};
            end else if (update_i && (error_reg == DmiOk)) begin
                if (busy) begin
                    error_next = DmiBusy;
                end else if ((upd_op == DtmRead) || (upd_op == DtmWrite)) begin
                    addr_next     = upd_addr;
                    req_next.data = upd_data;
                    req_next.op   = dtm_op_e'(upd_op);
                    state_next    = StReq;
                end
            end
        end

        // Request/response handshake toward the DM side
        case (state_reg)
            StReq: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) state_next = StWait;
            end
            StWait: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    req_next.data = resp.data;
                    if (resp.err && (error_next == DmiOk)) error_next = DmiFailed;
                    state_next = StIdle;
                end
            end
            default: ;
        endcase

        // DTMCS: only dmireset / dmihardreset act on update
        if (dtmcs_select_i) begin
            if (capture_i) begin
                dtmcs_sr_next = dtmcs_cap;
            end else if (shift_i) begin
                dtmcs_sr_next = {tdi_i, dtmcs_sr_reg[31:1]};
            end else if (update_i) begin
                if (dtmcs_sr_reg[16]) error_next = DmiOk;
`ifdef DMI_JTAG_HARDRESET_EN
                if (dtmcs_sr_reg[17]) begin
                    state_next    = StIdle;
                    error_next    = DmiOk;
                    hardreset_req = 1'b1;
                end
`endif
            end
        end
    end

    // State register
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_reg    <= StIdle;
            error_reg    <= DmiOk;
            addr_reg     <= '0;
            req_reg      <= '{data: 32'd0, op: DtmNop};
            dtmcs_sr_reg <= '0;
            dmi_sr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            error_reg    <= error_next;
            addr_reg     <= addr_next;
            req_reg      <= req_next;
            dtmcs_sr_reg <= dtmcs_sr_next;
            dmi_sr_reg   <= dmi_sr_next;
        end
    end

`ifdef DMI_JTAG_HARDRESET_EN
    // One-cycle active-low DM reset pulse following a hardreset update
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) dmi_rst_n_reg <= 1'b1;
        else          dmi_rst_n_reg <= ~hardreset_req;
    end
    assign dmi_rst_no = dmi_rst_n_reg;
`else
    assign dmi_rst_no = 1'b1;
`endif

endmodule

// File: tb/tb_dmi_jtag_ctrl.sv
// Directed testbench for dmi_jtag_ctrl: drives TAP DR strobes and plays the
// DM side by hand. Inputs change on the falling edge, outputs are sampled
// on the falling edge.
module tb_dmi_jtag_ctrl;

    localparam int AW = 7;
    localparam int DW = AW + 34;

    logic          tck = 1'b0;
    logic          trst_n;
    logic          capture, shift, update, tdi;
    logic          dtmcs_sel, dmi_sel;
    logic          dtmcs_tdo, dmi_tdo;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_op;
    logic [31:0]   req_data;
    logic          resp_valid, resp_ready, resp_err;
    logic [31:0]   resp_data;
    logic          rst_no;

    int checks = 0;
    int failures = 0;
    int req_count = 0;

    dmi_jtag_ctrl #(.AddrWidth(AW), .IdleHint(1)) dut (
        .tck_i            (tck),
        .trst_ni          (trst_n),
        .capture_i        (capture),
        .shift_i          (shift),
        .update_i         (update),
        .tdi_i            (tdi),
        .dtmcs_select_i   (dtmcs_sel),
        .dtmcs_tdo_o      (dtmcs_tdo),
        .dmi_select_i     (dmi_sel),
        .dmi_tdo_o        (dmi_tdo),
        .dmi_req_valid_o  (req_valid),
        .dmi_req_ready_i  (req_ready),
        .dmi_req_addr_o   (req_addr),
        .dmi_req_op_o     (req_op),
        .dmi_req_data_o   (req_data),
        .dmi_resp_valid_i (resp_valid),
        .dmi_resp_ready_o (resp_ready),
        .dmi_resp_data_i  (resp_data),
        .dmi_resp_err_i   (resp_err),
        .dmi_rst_no       (rst_no)
    );

    always #5 tck = ~tck;

    // Counts completed request handshakes
    always @(posedge tck) begin
        if (req_valid && req_ready) req_count++;
    end

    task automatic capture_dr(input logic to_dtmcs);
        dtmcs_sel = to_dtmcs;
        dmi_sel   = ~to_dtmcs;
        capture   = 1'b1;
        @(negedge tck);
        capture   = 1'b0;
    endtask

    task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = dtmcs_sel ? dtmcs_tdo : dmi_tdo;
            tdi     = din[i];
            shift   = 1'b1;
            @(negedge tck);
        end
        shift = 1'b0;
        tdi   = 1'b0;
    endtask

    task automatic update_dr();
        update = 1'b1;
        @(negedge tck);
        update = 1'b0;
    endtask

    task automatic dmi_access(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        logic [63:0] unused_dout;
        capture_dr(1'b0);
        shift_dr(DW, {23'd0, a, d, op}, unused_dout);
        update_dr();
    endtask

    task automatic dtmcs_access(input logic [31:0] v, output logic [31:0] captured);
        logic [63:0] dout;
        capture_dr(1'b1);
        shift_dr(32, {32'd0, v}, dout);
        captured = dout[31:0];
        update_dr();
    endtask

    task automatic dmi_read_back(output logic [40:0] value);
        logic [63:0] dout;
        capture_dr(1'b0);
        shift_dr(DW, 64'd0, dout);
        value = dout[40:0];
    endtask

    task automatic test_reset();
        trst_n = 1'b0;
        repeat (2) @(negedge tck);
        checks++;
        if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
        checks++;
        if (resp_ready !== 1'b0) begin failures++; $display("FAIL reset_resp_ready got=%b exp=0", resp_ready); end
        trst_n = 1'b1;
        @(negedge tck);
        checks++;
        if (dtmcs_tdo !== 1'b0) begin failures++; $display("FAIL reset_dtmcs_tdo got=%b exp=0", dtmcs_tdo); end
        checks++;
        if (dmi_tdo !== 1'b0) begin failures++; $display("FAIL reset_dmi_tdo got=%b exp=0", dmi_tdo); end
        checks++;
        if (rst_no !== 1'b1) begin failures++; $display("FAIL reset_dmi_rst_no got=%b exp=1", rst_no); end
        $display("test_reset done");
    endtask

    task automatic test_dtmcs();
        logic [31:0] cap;
        dtmcs_access(32'd0, cap);
        checks++;
        if (cap !== 32'h0000_1071) begin failures++; $display("FAIL dtmcs_capture got=%h exp=00001071", cap); end
        $display("test_dtmcs dtmcs=%h", cap);
    endtask

    task automatic test_read();
        logic [40:0] rb;
        dmi_access(7'h11, 32'd0, 2'd1);
        checks++;
        if ({req_valid, req_addr, req_op} !== {1'b1, 7'h11, 2'd1})
            begin failures++; $display("FAIL read_req got=%b/%h/%0d exp=1/11/1", req_valid, req_addr, req_op); end
        req_ready = 1'b1;
        @(negedge tck);
        req_ready = 1'b0;
        checks++;
        if ({req_valid, resp_ready} !== 2'b01)
            begin failures++; $display("FAIL read_wait got=%b%b exp=01", req_valid, resp_ready); end
        repeat (2) @(negedge tck);
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        @(negedge tck);
        resp_valid = 1'b0;
        checks++;
        if (resp_ready !== 1'b0) begin failures++; $display("FAIL read_idle resp_ready got=%b exp=0", resp_ready); end
        dmi_read_back(rb);
        checks++;
        if (rb !== {7'h11, 32'hDEAD_BEEF, 2'b00})
            begin failures++; $display("FAIL read_capture got=%h exp=%h", rb, {7'h11, 32'hDEAD_BEEF, 2'b00}); end
        $display("test_read capture=%h", rb);
    endtask

    task automatic test_write_stall();
        int base;
        base = req_count;
        dmi_access(7'h04, 32'h1234_5678, 2'd2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({req_valid, req_addr, req_op, req_data} !== {1'b1, 7'h04, 2'd2, 32'h1234_5678})
                begin failures++; $display("FAIL write_stall_%0d got=%b/%h/%0d/%h exp=1/04/2/12345678", i, req_valid, req_addr, req_op, req_data); end
            @(negedge tck);
        end
        req_ready = 1'b1;
        @(negedge tck);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'h0BAD_F00D;
        @(negedge tck);
        resp_valid = 1'b0;
        repeat (3) @(negedge tck);
        checks++;
        if ((req_count - base) !== 1) begin failures++; $display("FAIL write_req_count got=%0d exp=1", req_count - base); end
        checks++;
        if (req_valid !== 1'b0) begin failures++; $display("FAIL write_no_replay got=%b exp=0", req_valid); end
        $display("test_write_stall requests=%0d", req_count - base);
    endtask

    task automatic test_busy();
        logic [40:0] rb;
        logic [31:0] cap;
        int base;
        dmi_access(7'h05, 32'd0, 2'd1);
        req_ready = 1'b1;
        @(negedge tck);
        req_ready = 1'b0;
        dmi_access(7'h22, 32'd0, 2'd1);
        checks++;
        if ({req_valid, resp_ready} !== 2'b01)
            begin failures++; $display("FAIL busy_inflight got=%b%b exp=01", req_valid, resp_ready); end
        resp_valid = 1'b1;
        resp_data  = 32'h55AA_55AA;
        @(negedge tck);
        resp_valid = 1'b0;
        dmi_read_back(rb);
        checks++;
        if (rb !== {7'h05, 32'h55AA_55AA, 2'b11})
            begin failures++; $display("FAIL busy_capture got=%h exp=%h", rb, {7'h05, 32'h55AA_55AA, 2'b11}); end
        dtmcs_access(32'd0, cap);
        checks++;
        if (cap !== 32'h0000_1C71) begin failures++; $display("FAIL busy_dtmcs got=%h exp=00001C71", cap); end
        base = req_count;
        dmi_access(7'h11, 32'd0, 2'd1);
        checks++;
        if (req_valid !== 1'b0) begin failures++; $display("FAIL busy_ignored_valid got=%b exp=0", req_valid); end
        repeat (3) @(negedge tck);
        checks++;
        if ((req_count - base) !== 0) begin failures++; $display("FAIL busy_ignored_count got=%0d exp=0", req_count - base); end
        dtmcs_access(32'h0001_0000, cap);
        dtmcs_access(32'd0, cap);
        checks++;
        if (cap !== 32'h0000_1071) begin failures++; $display("FAIL dmireset_dtmcs got=%h exp=00001071", cap); end
        dmi_access(7'h11, 32'd0, 2'd1);
        checks++;
        if (req_valid !== 1'b1) begin failures++; $display("FAIL after_reset_req got=%b exp=1", req_valid); end
        req_ready = 1'b1;
        @(negedge tck);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'h1357_9BDF;
        @(negedge tck);
        resp_valid = 1'b0;
        dmi_read_back(rb);
        checks++;
        if (rb !== {7'h11, 32'h1357_9BDF, 2'b00})
            begin failures++; $display("FAIL after_reset_capture got=%h exp=%h", rb, {7'h11, 32'h1357_9BDF, 2'b00}); end
        $display("test_busy capture=%h", rb);
    endtask

    task automatic test_resp_err();
        logic [40:0] rb;
        logic [31:0] cap;
        dmi_access(7'h07, 32'd0, 2'd1);
        req_ready = 1'b1;
        @(negedge tck);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        resp_data  = 32'h0000_FFFF;
        @(negedge tck);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dmi_read_back(rb);
            checks++;
            if (rb !== {7'h07, 32'h0000_FFFF, 2'b10})
                begin failures++; $display("FAIL err_capture_%0d got=%h exp=%h", i, rb, {7'h07, 32'h0000_FFFF, 2'b10}); end
        end
        dtmcs_access(32'd0, cap);
        checks++;
        if (cap !== 32'h0000_1871) begin failures++; $display("FAIL err_dtmcs got=%h exp=00001871", cap); end
        dtmcs_access(32'h0001_0000, cap);
        $display("test_resp_err capture=%h", rb);
    endtask

    task automatic test_trst();
        logic [40:0] rb;
        int base;
        base = req_count;
        dmi_access(7'h33, 32'h0000_000A, 2'd2);
        checks++;
        if (req_valid !== 1'b1) begin failures++; $display("FAIL trst_pre_valid got=%b exp=1", req_valid); end
        #2 trst_n = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0) begin failures++; $display("FAIL trst_async_valid got=%b exp=0", req_valid); end
        @(negedge tck);
        trst_n = 1'b1;
        repeat (3) @(negedge tck);
        checks++;
        if ({req_valid, (req_count - base)} !== {1'b0, 32'd0})
            begin failures++; $display("FAIL trst_no_replay got=%b/%0d exp=0/0", req_valid, req_count - base); end
        dmi_read_back(rb);
        checks++;
        if (rb !== 41'd0) begin failures++; $display("FAIL trst_capture got=%h exp=0", rb); end
        $display("test_trst capture=%h", rb);
    endtask

    task automatic test_hardreset();
        logic [31:0] cap;
        dmi_access(7'h09, 32'd0, 2'd1);
        req_ready = 1'b1;
        @(negedge tck);
        req_ready = 1'b0;
`ifdef DMI_JTAG_HARDRESET_EN
        dmi_access(7'h09, 32'd0, 2'd1);
        checks++;
        if (rst_no !== 1'b1) begin failures++; $display("FAIL hardreset_pre_rst got=%b exp=1", rst_no); end
        dtmcs_access(32'h0002_0000, cap);
        checks++;
        if ({req_valid, resp_ready, rst_no} !== 3'b000)
            begin failures++; $display("FAIL hardreset_pulse got=%b%b%b exp=000", req_valid, resp_ready, rst_no); end
        @(negedge tck);
        checks++;
        if (rst_no !== 1'b1) begin failures++; $display("FAIL hardreset_pulse_end got=%b exp=1", rst_no); end
        dtmcs_access(32'd0, cap);
        checks++;
        if (cap !== 32'h0000_1071) begin failures++; $display("FAIL hardreset_dtmcs got=%h exp=00001071", cap); end
        $display("test_hardreset dtmcs=%h", cap);
`else
        dtmcs_access(32'h0002_0000, cap);
        checks++;
        if ({resp_ready, rst_no} !== 2'b11)
            begin failures++; $display("FAIL hardreset_ignored got=%b%b exp=11", resp_ready, rst_no); end
        @(negedge tck);
        checks++;
        if (rst_no !== 1'b1) begin failures++; $display("FAIL hardreset_rst_tied got=%b exp=1", rst_no); end
        resp_valid = 1'b1;
        resp_data  = 32'h0000_0001;
        @(negedge tck);
        resp_valid = 1'b0;
        checks++;
        if (resp_ready !== 1'b0) begin failures++; $display("FAIL hardreset_finish got=%b exp=0", resp_ready); end
        $display("test_hardreset bit17 ignored");
`endif
    endtask

    initial begin
        trst_n     = 1'b0;
        capture    = 1'b0;
        shift      = 1'b0;
        update     = 1'b0;
        tdi        = 1'b0;
        dtmcs_sel  = 1'b0;
        dmi_sel    = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = 32'd0;
        @(negedge tck);
        test_reset();
        test_dtmcs();
        test_read();
        test_write_stall();
        test_busy();
        test_resp_err();
        test_trst();
        test_hardreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
